// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle controller.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       iord;
  logic       ir_write;
  logic       mem_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_instr;
  logic [3:0] state;

  modport master (
    input  opcode,
    input  funct,
    input  zero_flag,
    output alu_control,
    output alu_src_a,
    output alu_src_b,
    output pc_src,
    output pc_en,
    output iord,
    output ir_write,
    output mem_write,
    output reg_dst,
    output mem_to_reg,
    output reg_write,
    output illegal_instr,
    output state
  );

  modport slave (
    output opcode,
    output funct,
    output zero_flag,
    input  alu_control,
    input  alu_src_a,
    input  alu_src_b,
    input  pc_src,
    input  pc_en,
    input  iord,
    input  ir_write,
    input  mem_write,
    input  reg_dst,
    input  mem_to_reg,
    input  reg_write,
    input  illegal_instr,
    input  state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: Moore FSM
// driving PC, memory, IR, register-file and ALU strobes.
package mc_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTY  = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
endpackage

module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  multicycle_ctrl_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  logic       op_ok;
  logic       fn_ok;
  logic [2:0] fn_alu;

  logic [2:0] alu_c;
  logic       src_a;
  logic [1:0] src_b;
  logic [1:0] pcs;
  logic       pc_wr;
  logic       iord_c;
  logic       irw_c;
  logic       mw_c;
  logic       rd_c;
  logic       m2r_c;
  logic       rw_c;
  logic       ill_c;

  // State register; reset is asynchronous so it can abort mid-instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode legality, consulted only while in DECODE
  always_comb begin
    op_ok = 1'b1;
    unique case (1'b1)
      (bus.opcode == OP_LW):   op_ok = 1'b1;
      (bus.opcode == OP_SW):   op_ok = 1'b1;
      (bus.opcode == OP_RTY):  op_ok = 1'b1;
      (bus.opcode == OP_BEQ):  op_ok = 1'b1;
      (bus.opcode == OP_ADDI): op_ok = 1'b1;
      (bus.opcode == OP_J):    op_ok = 1'b1;
      default:                 op_ok = 1'b0;
    endcase
  end

  // R-type funct to ALU command; unknown funct falls back to ADD
  always_comb begin
    fn_ok  = 1'b1;
    fn_alu = ALU_ADD;
    unique case (1'b1)
      (bus.funct == FN_ADD): fn_alu = ALU_ADD;
      (bus.funct == FN_SUB): fn_alu = ALU_SUB;
      (bus.funct == FN_AND): fn_alu = ALU_AND;
      (bus.funct == FN_OR):  fn_alu = ALU_OR;
      (bus.funct == FN_SLT): fn_alu = ALU_SLT;
      default: begin
        fn_ok  = 1'b0;
        fn_alu = ALU_ADD;
      end
    endcase
  end

  // Next-state logic; unused codes recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (bus.opcode == OP_LW):   state_d = S_MEMADR;
          (bus.opcode == OP_SW):   state_d = S_MEMADR;
          (bus.opcode == OP_RTY):  state_d = S_EXEC;
          (bus.opcode == OP_BEQ):  state_d = S_BRANCH;
          (bus.opcode == OP_ADDI): state_d = S_ADDIEX;
          (bus.opcode == OP_J):    state_d = S_JUMP;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC: begin
        if (fn_ok) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; everything idles at 0 unless a state claims it
  always_comb begin
    alu_c  = ALU_AND;
    src_a  = 1'b0;
    src_b  = 2'b00;
    pcs    = 2'b00;
    pc_wr  = 1'b0;
    iord_c = 1'b0;
    irw_c  = 1'b0;
    mw_c   = 1'b0;
    rd_c   = 1'b0;
    m2r_c  = 1'b0;
    rw_c   = 1'b0;
    ill_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        irw_c = 1'b1;
        src_b = 2'b01;
        alu_c = ALU_ADD;
        pc_wr = 1'b1;
      end
      S_DECODE: begin
        src_b = 2'b11;
        alu_c = ALU_ADD;
        ill_c = !op_ok;
      end
      S_MEMADR: begin
        src_a = 1'b1;
        src_b = 2'b10;
        alu_c = ALU_ADD;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
      end
      S_MEMWB: begin
        m2r_c = 1'b1;
        rw_c  = 1'b1;
      end
      S_MEMWR: begin
        iord_c = 1'b1;
        mw_c   = 1'b1;
      end
      S_EXEC: begin
        src_a = 1'b1;
        alu_c = fn_alu;
        ill_c = !fn_ok;
      end
      S_ALUWB: begin
        rd_c = 1'b1;
        rw_c = 1'b1;
      end
      S_BRANCH: begin
        src_a = 1'b1;
        alu_c = ALU_SUB;
        pcs   = 2'b01;
        pc_wr = bus.zero_flag;
      end
      S_ADDIEX: begin
        src_a = 1'b1;
        src_b = 2'b10;
        alu_c = ALU_ADD;
      end
      S_ADDIWB: begin
        rw_c = 1'b1;
      end
      S_JUMP: begin
        pcs   = 2'b10;
        pc_wr = 1'b1;
      end
      default: begin
        alu_c = ALU_AND;
      end
    endcase
  end

  // PC and IR writes are held off while reset is asserted
  always_comb begin
    bus.alu_control   = alu_c;
    bus.alu_src_a     = src_a;
    bus.alu_src_b     = src_b;
    bus.pc_src        = pcs;
    bus.pc_en         = pc_wr & rst_n;
    bus.iord          = iord_c;
    bus.ir_write      = irw_c & rst_n;
    bus.mem_write     = mw_c;
    bus.reg_dst       = rd_c;
    bus.mem_to_reg    = m2r_c;
    bus.reg_write     = rw_c;
    bus.illegal_instr = ill_c & rst_n;
    bus.state         = state_q;
  end

endmodule
